// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer with PC, redirect and ID hand-off.
// Optional misaligned-redirect trap enabled by defining NPC_MISALIGN_TRAP_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        stall,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_gnt,
    input  logic        if_rvalid,
    input  logic [31:0] if_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        misalign
);
`ifdef NPC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic        redir;
    logic        bad;
    logic [31:0] target;
    assign redir    = redir_valid && state != IDLE;
    assign bad      = TRAP_EN && redir_pc[1:0] != 2'b00;
    assign target   = bad ? TRAP_VEC : {redir_pc[31:2], 2'b00};
    assign if_req   = state == REQ;
    assign if_addr  = pc;
    assign id_valid = state == FULL;
    assign id_pc4   = id_pc + 32'd4;
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            id_inst  <= '0;
            id_pc    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= redir && bad;
            if (redir) pc <= target;
            case (state)
                IDLE: state <= REQ;
                REQ: if (if_gnt) begin
                    state <= WAIT;
                    drop  <= redir;
                end
                WAIT: if (if_rvalid) begin
                    drop  <= 1'b0;
                    state <= REQ;
                    // a redirect racing the response kills the data just like a pending drop
                    if (!drop && !redir) begin
                        id_inst <= if_rdata;
                        id_pc   <= pc;
                        pc      <= pc + 32'd4;
                        state   <= FULL;
                    end
                end else if (redir) drop <= 1'b1;
                FULL: if (redir || (id_ready && !stall)) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        stall = 1'b0;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt = 1'b0;
    logic        if_rvalid = 1'b0;
    logic [31:0] if_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        misalign;
    int total = 0;
    int bad = 0;

    fetch_ctrl dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .stall(stall), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4), .misalign(misalign)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset;
        cpu_rst = 1'b1;
        tick();
        tick();
        total++; if (if_req !== 1'b0) begin bad++; $display("FAIL rst_if_req got=%b exp=0", if_req); end
        total++; if (if_addr !== 32'h0) begin bad++; $display("FAIL rst_if_addr got=%h exp=0", if_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
        total++; if (id_inst !== 32'h0) begin bad++; $display("FAIL rst_id_inst got=%h exp=0", id_inst); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
        total++; if (id_pc4 !== 32'h4) begin bad++; $display("FAIL rst_id_pc4 got=%h exp=4", id_pc4); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
        cpu_rst = 1'b0;
        tick();
        total++; if (if_req !== 1'b1) begin bad++; $display("FAIL rel_if_req got=%b exp=1", if_req); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] a;
        id_ready = 1'b1;
        if_rdata = 32'h0000_0013;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            total++; if (if_req !== 1'b1 || if_addr !== a) begin bad++; $display("FAIL zw_req%0d got=%b/%h exp=1/%h", i, if_req, if_addr, a); end
            if_gnt = 1'b1;
            tick();
            if_gnt = 1'b0;
            total++; if (if_req !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL zw_wait%0d got=%b/%b exp=0/0", i, if_req, id_valid); end
            if_rvalid = 1'b1;
            tick();
            if_rvalid = 1'b0;
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL zw_valid%0d got=%b exp=1", i, id_valid); end
            total++; if (id_pc !== a || id_pc4 !== a + 32'd4) begin bad++; $display("FAIL zw_pc%0d got=%h/%h exp=%h/%h", i, id_pc, id_pc4, a, a + 32'd4); end
            total++; if (id_inst !== 32'h13) begin bad++; $display("FAIL zw_inst%0d got=%h exp=00000013", i, id_inst); end
            tick();
        end
    endtask

    task automatic test_backpressure;
        id_ready = 1'b0;
        if_gnt = 1'b1;
        tick();
        if_gnt = 1'b0;
        if_rvalid = 1'b1;
        if_rdata = 32'hAAAA_0001;
        tick();
        if_rvalid = 1'b0;
        if_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            total++; if (id_valid !== 1'b1 || if_req !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got=%b/%b exp=1/0", i, id_valid, if_req); end
            total++; if (id_inst !== 32'hAAAA_0001 || id_pc !== 32'hC) begin bad++; $display("FAIL bp_buf%0d got=%h/%h exp=aaaa0001/0000000c", i, id_inst, id_pc); end
            tick();
        end
        id_ready = 1'b1;
        tick();
        total++; if (id_valid !== 1'b0 || if_req !== 1'b1 || if_addr !== 32'h10) begin bad++; $display("FAIL bp_release got=%b/%b/%h exp=0/1/00000010", id_valid, if_req, if_addr); end
    endtask

    task automatic test_redirect_wait;
        if_gnt = 1'b1;
        tick();
        if_gnt = 1'b0;
        redir_valid = 1'b1;
        redir_pc = 32'h100;
        tick();
        redir_valid = 1'b0;
        tick();
        total++; if (if_req !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL rw_wait got=%b/%b exp=0/0", if_req, id_valid); end
        if_rvalid = 1'b1;
        if_rdata = 32'hDEAD_BEEF;
        tick();
        if_rvalid = 1'b0;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rw_dropped got=%b exp=0", id_valid); end
        total++; if (if_req !== 1'b1 || if_addr !== 32'h100) begin bad++; $display("FAIL rw_addr got=%b/%h exp=1/00000100", if_req, if_addr); end
    endtask

    task automatic test_redirect_gnt_stall;
        stall = 1'b1;
        if_gnt = 1'b1;
        redir_valid = 1'b1;
        redir_pc = 32'h200;
        tick();
        if_gnt = 1'b0;
        redir_valid = 1'b0;
        total++; if (if_req !== 1'b0) begin bad++; $display("FAIL rg_wait got=%b exp=0", if_req); end
        if_rvalid = 1'b1;
        if_rdata = 32'h1111_1111;
        tick();
        if_rvalid = 1'b0;
        total++; if (id_valid !== 1'b0 || if_addr !== 32'h200) begin bad++; $display("FAIL rg_drop got=%b/%h exp=0/00000200", id_valid, if_addr); end
        if_gnt = 1'b1;
        tick();
        if_gnt = 1'b0;
        if_rvalid = 1'b1;
        if_rdata = 32'h0000_0055;
        tick();
        if_rvalid = 1'b0;
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin bad++; $display("FAIL rg_stall_hold got=%b/%h exp=1/00000200", id_valid, id_pc); end
        redir_valid = 1'b1;
        redir_pc = 32'h300;
        tick();
        redir_valid = 1'b0;
        stall = 1'b0;
        total++; if (id_valid !== 1'b0 || if_req !== 1'b1 || if_addr !== 32'h300) begin bad++; $display("FAIL rg_flush got=%b/%b/%h exp=0/1/00000300", id_valid, if_req, if_addr); end
        if_gnt = 1'b1;
        tick();
        if_gnt = 1'b0;
        if_rvalid = 1'b1;
        redir_valid = 1'b1;
        redir_pc = 32'h400;
        tick();
        if_rvalid = 1'b0;
        redir_valid = 1'b0;
        total++; if (id_valid !== 1'b0 || if_req !== 1'b1 || if_addr !== 32'h400) begin bad++; $display("FAIL rg_race got=%b/%b/%h exp=0/1/00000400", id_valid, if_req, if_addr); end
        redir_valid = 1'b1;
        redir_pc = 32'h500;
        tick();
        redir_valid = 1'b0;
        total++; if (if_req !== 1'b1 || if_addr !== 32'h500) begin bad++; $display("FAIL rg_retract got=%b/%h exp=1/00000500", if_req, if_addr); end
    endtask

    task automatic test_wrap;
        redir_valid = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        total++; if (if_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", if_addr); end
        if_gnt = 1'b1;
        tick();
        if_gnt = 1'b0;
        if_rvalid = 1'b1;
        if_rdata = 32'h0000_0073;
        tick();
        if_rvalid = 1'b0;
        total++; if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/00000000", id_pc, id_pc4); end
        tick();
        total++; if (if_req !== 1'b1 || if_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%b/%h exp=1/00000000", if_req, if_addr); end
    endtask

    task automatic test_misalign;
        logic [31:0] ea;
        logic        em;
`ifdef NPC_MISALIGN_TRAP_EN
        ea = 32'h10;
        em = 1'b1;
`else
        ea = 32'h100;
        em = 1'b0;
`endif
        redir_valid = 1'b1;
        redir_pc = 32'h102;
        tick();
        redir_valid = 1'b0;
        total++; if (misalign !== em || if_addr !== ea) begin bad++; $display("FAIL mis_redir got=%b/%h exp=%b/%h", misalign, if_addr, em, ea); end
        tick();
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", misalign); end
    endtask

    task automatic test_reset_mid;
        if_gnt = 1'b1;
        tick();
        if_gnt = 1'b0;
        cpu_rst = 1'b1;
        tick();
        total++; if (if_req !== 1'b0 || id_valid !== 1'b0 || if_addr !== 32'h0) begin bad++; $display("FAIL mid_rst got=%b/%b/%h exp=0/0/00000000", if_req, id_valid, if_addr); end
        cpu_rst = 1'b0;
        tick();
        if_rvalid = 1'b1;
        if_rdata = 32'hBAD0_BAD0;
        tick();
        if_rvalid = 1'b0;
        total++; if (if_req !== 1'b1 || id_valid !== 1'b0 || if_addr !== 32'h0) begin bad++; $display("FAIL mid_late got=%b/%b/%h exp=1/0/00000000", if_req, id_valid, if_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt_stall();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
